fifo_wr_arbiter: RTL

Round-robin arbiter that shares one FIFO write port among NUM_REQ requesters in the DRAM cache datapath (fill, writeback and eviction sources into a shared command/data FIFO). Requests are multi-beat packets delimited by req_last. A granted packet is written contiguously and never interleaved with another. New packets start only when the FIFO is not almost-full, and individual beats stall on full.

---
 rtl/fifo_wr_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ packet sources.
// A granted packet is written contiguously; packet starts are gated by A_full, beats by full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      full,
    input  logic                      A_full,
    output logic                      write_en,
    output logic [DATA_W-1:0]         write_data,
    output logic                      busy,
    output logic [ID_W-1:0]           owner
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   owner_reg, owner_next;
    logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_found;
    logic [DATA_W-1:0] beat [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign beat[gi]      = req_data[gi*DATA_W +: DATA_W];
            assign req_ready[gi] = (state_reg == BURST) && (owner_reg == ID_W'(gi)) && !full;
        end
    endgenerate

    // Search starts at rr_ptr and wraps modulo NUM_REQ, so indices >= NUM_REQ never appear.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_found && req_valid[ID_W'(idx)]) begin
                pick_found = 1'b1;
                pick_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        write_en    = 1'b0;
        write_data  = beat[owner_reg];
        case (state_reg)
            IDLE: begin
                if (pick_found && !A_full && !full) begin
                    state_next = BURST;
                    owner_next = pick_idx;
                end
            end
            BURST: begin
                write_en = req_valid[owner_reg] && !full;
                if (write_en && req_last[owner_reg]) begin
                    state_next  = IDLE;
                    rr_ptr_next = ID_W'((int'(owner_reg) + 1) % NUM_REQ);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            owner_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    assign busy  = (state_reg == BURST);
    assign owner = owner_reg;

endmodule
